ccd_capture_ctrl: RTL and testbench
===================================

CCD_CAPTURE_CTRL -- requirements
Module: ccd_capture_ctrl

Interface
REQ-001 Parameter: FRAME_CNT_W, default 16, width of the captured-frame counter.
REQ-002 Parameter: X_W, default 12, pixel-column counter width; Y_W, default 12, line counter width.
REQ-003 im_D5M_PIXLCLK  in  1  single clock; all logic on its rising edge.
REQ-004 im_RST  in  1  reset; synchronous, active-high.
REQ-005 im_rCCD_DATA  in  12  registered sensor pixel data.
REQ-006 im_rCCD_LVAL / im_rCCD_FVAL  in  1 each  registered line-valid / frame-valid.
REQ-007 im_START  in  1  one-cycle request to begin continuous capture.
REQ-008 im_STOP  in  1  one-cycle request to end capture at the next frame boundary.
REQ-009 im_SNAP  in  1  one-cycle request to capture exactly one frame.
REQ-010 om_DATA  out  12  captured pixel; om_DVAL  out  1  pixel qualifier.
REQ-011 om_X_CNT  out  X_W, om_Y_CNT  out  Y_W  coordinates of the pixel on om_DATA.
REQ-012 om_FRAME_CNT  out  FRAME_CNT_W  completed captured frames, wraps at 2^FRAME_CNT_W.
REQ-013 om_BUSY  out  1  high in any state except IDLE; om_FRAME_DONE  out  1  one-cycle pulse at end of each captured frame.

Function
REQ-014 States: IDLE, ARM (wait for FVAL rising edge), CAPTURE, DRAIN (finish current frame then IDLE).
REQ-015 IDLE -> ARM on im_START or im_SNAP; a SNAP arms single-shot mode, START clears it.
REQ-016 ARM -> CAPTURE on the cycle a rising edge of im_rCCD_FVAL is detected (FVAL high, previous FVAL low); a frame already in progress on arming is never partially captured.
REQ-017 CAPTURE -> DRAIN on im_STOP; DRAIN and single-shot CAPTURE -> IDLE on FVAL falling edge.
REQ-018 Continuous CAPTURE at FVAL falling edge stays CAPTURE and re-arms for the next FVAL rising edge without leaving the state.
REQ-019 im_START/im_SNAP while not IDLE are ignored; im_STOP in ARM returns to IDLE next cycle; im_STOP in IDLE ignored.
REQ-020 Simultaneous im_STOP with im_START or im_SNAP: STOP wins; simultaneous START and SNAP in IDLE: START wins.
REQ-021 om_DVAL = registered (LVAL & FVAL & state in CAPTURE/DRAIN with frame active); latency exactly 1 clock from input to om_DATA/om_DVAL.
REQ-022 om_X_CNT increments per valid pixel, clears to 0 on LVAL falling edge; saturates at 2^X_W-1.
REQ-023 om_Y_CNT increments on LVAL falling edge inside a captured frame, clears on FVAL rising edge; saturates at 2^Y_W-1.
REQ-024 om_FRAME_DONE pulses and om_FRAME_CNT increments on the cycle after FVAL falls in a captured frame.
REQ-025 om_DATA holds its last value when om_DVAL is low.

Reset
REQ-026 im_RST high: state IDLE, single-shot flag 0, all outputs 0, edge-detect history 0.
REQ-027 Reset mid-frame aborts capture; after release, capture requires a new request and a new FVAL rising edge.

Configuration
REQ-028 Macro CCD_TEST_PATTERN_EN defined: input im_TEST_PAT (1 bit) added; when high, om_DATA = {om_X_CNT[5:0], om_Y_CNT[5:0]} of the same pixel, timing unchanged.
REQ-029 Macro undefined: no im_TEST_PAT port; om_DATA always sensor data.

Structure
REQ-030 Shared package ccd_pkg holds the state enum and the 12-bit pixel width constant.
REQ-031 One sub-module ccd_edge_det (rise/fall detect of LVAL and FVAL), instantiated twice.

Verification
REQ-032 START, then 2 frames of 3 lines x 4 pixels -> 24 om_DVAL pulses, X 0..3, Y 0..2, om_FRAME_CNT 2, two om_FRAME_DONE pulses.
REQ-033 START asserted mid-frame (FVAL high) -> no om_DVAL until next FVAL rise; first pixel X=0,Y=0.
REQ-034 SNAP then 3 frames -> exactly 12 om_DVAL, om_FRAME_CNT 1, om_BUSY low after frame 1 ends.
REQ-035 STOP in line 2 of frame -> remaining pixels of that frame delivered, none of next frame, IDLE after FVAL fall.
REQ-036 START and STOP same cycle in IDLE -> stays IDLE; im_RST mid-line -> all outputs 0 next cycle, no further om_DVAL.
REQ-037 CCD_TEST_PATTERN_EN with im_TEST_PAT=1, pixel X=2,Y=1 -> om_DATA = 12'h081.

Source files
------------

// File: rtl/ccd_pkg.sv
// ccd_pkg: shared types and constants for the CCD capture controller
package ccd_pkg;
  localparam int PIX_W = 12;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;
endpackage

// File: rtl/ccd_edge_det.sv
// ccd_edge_det: rise/fall detector for one registered sensor strobe
// Ports: im_D5M_PIXLCLK clock, im_RST sync active-high reset, sig strobe in,
//        rise/fall combinational pulses in the cycle sig changes level.
module ccd_edge_det (
  input  logic im_D5M_PIXLCLK,
  input  logic im_RST,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge im_D5M_PIXLCLK) prev <= im_RST ? 1'b0 : sig;
  assign rise = sig & ~prev;
  assign fall = ~sig & prev;
endmodule

// File: rtl/ccd_capture_ctrl.sv
// ccd_capture_ctrl: start/stop/snap controlled frame capture from a D5M-style sensor stream
// Ports: im_D5M_PIXLCLK clock, im_RST sync active-high reset,
//        im_rCCD_DATA/LVAL/FVAL registered sensor stream, im_START/im_STOP/im_SNAP requests,
//        om_DATA/om_DVAL captured pixel (1-cycle latency), om_X_CNT/om_Y_CNT pixel coordinates,
//        om_FRAME_CNT completed frames, om_BUSY not idle, om_FRAME_DONE end-of-frame pulse.
// Build option: CCD_TEST_PATTERN_EN adds im_TEST_PAT, replacing pixel data with {X[5:0],Y[5:0]}.
module ccd_capture_ctrl
  import ccd_pkg::*;
#(
  parameter int FRAME_CNT_W = 16,
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input  logic                   im_D5M_PIXLCLK,
  input  logic                   im_RST,
  input  logic [PIX_W-1:0]       im_rCCD_DATA,
  input  logic                   im_rCCD_LVAL,
  input  logic                   im_rCCD_FVAL,
  input  logic                   im_START,
  input  logic                   im_STOP,
  input  logic                   im_SNAP,
`ifdef CCD_TEST_PATTERN_EN
  input  logic                   im_TEST_PAT,
`endif
  output logic [PIX_W-1:0]       om_DATA,
  output logic                   om_DVAL,
  output logic [X_W-1:0]         om_X_CNT,
  output logic [Y_W-1:0]         om_Y_CNT,
  output logic [FRAME_CNT_W-1:0] om_FRAME_CNT,
  output logic                   om_BUSY,
  output logic                   om_FRAME_DONE
);
  state_t state, state_nxt;
  logic single, single_nxt;
  logic frame_active, start_now, cur_active, dval_nxt, frame_end;
  logic l_rise, l_fall, f_rise, f_fall;
  logic [X_W-1:0] x_nxt, xc;
  logic [PIX_W-1:0] pix;

  ccd_edge_det u_lval (
    .im_D5M_PIXLCLK(im_D5M_PIXLCLK), .im_RST(im_RST), .sig(im_rCCD_LVAL),
    .rise(l_rise), .fall(l_fall)
  );
  ccd_edge_det u_fval (
    .im_D5M_PIXLCLK(im_D5M_PIXLCLK), .im_RST(im_RST), .sig(im_rCCD_FVAL),
    .rise(f_rise), .fall(f_fall)
  );

  // A captured frame starts only on an FVAL rise seen while armed or continuously capturing.
  assign start_now  = f_rise & ~im_STOP & (state == ARM || state == CAPTURE);
  assign cur_active = frame_active | start_now;
  assign dval_nxt   = im_rCCD_LVAL & im_rCCD_FVAL & cur_active;
  assign frame_end  = f_fall & frame_active;
  // First pixel of every line is column 0 regardless of leftover count.
  assign xc         = l_rise ? '0 : x_nxt;
  assign om_BUSY    = state != IDLE;

`ifdef CCD_TEST_PATTERN_EN
  assign pix = im_TEST_PAT ? {xc[5:0], om_Y_CNT[5:0]} : im_rCCD_DATA;
`else
  assign pix = im_rCCD_DATA;
`endif

  always_comb begin
    state_nxt  = state;
    single_nxt = single;
    case (state)
      IDLE:
        if (!im_STOP && (im_START || im_SNAP)) begin
          state_nxt  = ARM;
          single_nxt = ~im_START;
        end
      ARM:     state_nxt = im_STOP ? IDLE : f_rise ? CAPTURE : ARM;
      // STOP between frames has nothing to drain; STOP on the last cycle ends now.
      CAPTURE: state_nxt = (f_fall && (single || im_STOP)) || (im_STOP && !frame_active) ? IDLE :
                           im_STOP ? DRAIN : CAPTURE;
      DRAIN:   state_nxt = f_fall ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge im_D5M_PIXLCLK) begin
    if (im_RST) begin
      state         <= IDLE;
      single        <= 1'b0;
      frame_active  <= 1'b0;
      x_nxt         <= '0;
      om_X_CNT      <= '0;
      om_Y_CNT      <= '0;
      om_DATA       <= '0;
      om_DVAL       <= 1'b0;
      om_FRAME_CNT  <= '0;
      om_FRAME_DONE <= 1'b0;
    end else begin
      state         <= state_nxt;
      single        <= single_nxt;
      frame_active  <= start_now | (frame_active & ~f_fall);
      om_DVAL       <= dval_nxt;
      om_FRAME_DONE <= frame_end;
      if (frame_end) om_FRAME_CNT <= om_FRAME_CNT + FRAME_CNT_W'(1);
      if (start_now) om_Y_CNT <= '0;
      else if (l_fall && frame_active) om_Y_CNT <= (om_Y_CNT == '1) ? om_Y_CNT : om_Y_CNT + Y_W'(1);
      if (dval_nxt) begin
        om_DATA  <= pix;
        om_X_CNT <= xc;
        x_nxt    <= (xc == '1) ? xc : xc + X_W'(1);
      end else if (l_fall) begin
        om_X_CNT <= '0;
        x_nxt    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// tb_ccd_capture_ctrl: directed vector table plus multi-cycle sequences for ccd_capture_ctrl
module tb_ccd_capture_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lval, fval, start, stop, snap, tp;
  logic [11:0] data, o_data, o_x, o_y;
  logic [15:0] o_fcnt;
  logic o_dval, o_busy, o_done;
  int n_chk = 0, n_fail = 0, n_dval = 0, n_done = 0;

  ccd_capture_ctrl dut (
    .im_D5M_PIXLCLK(clk), .im_RST(rst), .im_rCCD_DATA(data),
    .im_rCCD_LVAL(lval), .im_rCCD_FVAL(fval),
    .im_START(start), .im_STOP(stop), .im_SNAP(snap),
`ifdef CCD_TEST_PATTERN_EN
    .im_TEST_PAT(tp),
`endif
    .om_DATA(o_data), .om_DVAL(o_dval), .om_X_CNT(o_x), .om_Y_CNT(o_y),
    .om_FRAME_CNT(o_fcnt), .om_BUSY(o_busy), .om_FRAME_DONE(o_done)
  );

  typedef struct {
    logic [5:0]  in;
    logic [11:0] d;
    logic        dv;
    logic [11:0] od, x, y;
    logic        busy, done;
    logic [15:0] fc;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(logic r, logic s, logic p, logic n, logic l, logic f, logic [11:0] d);
    rst = r; start = s; stop = p; snap = n; lval = l; fval = f; data = d;
    @(posedge clk);
    #1;
    if (o_dval) n_dval++;
    if (o_done) n_done++;
  endtask

  task automatic send_frame(int lines, int pix, int stop_line);
    logic [11:0] code, exp;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < pix; p++) begin
        code = 12'h800 | 12'(l * 16 + p);
        cyc(1'b0, 1'b0, (l == stop_line && p == 0), 1'b0, 1'b1, 1'b1, code);
        exp = tp ? {6'(p), 6'(l)} : code;
        if (o_dval) begin
          chk("pix_x", o_x, p);
          chk("pix_y", o_y, l);
          chk("pix_data", o_data, exp);
        end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    n_dval = 0;
    n_done = 0;
  endtask

  initial begin
    tp = 1'b0;
    // in = {rst, start, stop, snap, lval, fval}
    tbl[0]  = '{6'b100000, 12'h000, 1'b0, 12'h000, 12'd0, 12'd0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{6'b000100, 12'h000, 1'b0, 12'h000, 12'd0, 12'd0, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{6'b000001, 12'h000, 1'b0, 12'h000, 12'd0, 12'd0, 1'b1, 1'b0, 16'd0};
    tbl[3]  = '{6'b000011, 12'h111, 1'b1, 12'h111, 12'd0, 12'd0, 1'b1, 1'b0, 16'd0};
    tbl[4]  = '{6'b000011, 12'h222, 1'b1, 12'h222, 12'd1, 12'd0, 1'b1, 1'b0, 16'd0};
    tbl[5]  = '{6'b000001, 12'h000, 1'b0, 12'h222, 12'd0, 12'd1, 1'b1, 1'b0, 16'd0};
    tbl[6]  = '{6'b000011, 12'h333, 1'b1, 12'h333, 12'd0, 12'd1, 1'b1, 1'b0, 16'd0};
    tbl[7]  = '{6'b000011, 12'h444, 1'b1, 12'h444, 12'd1, 12'd1, 1'b1, 1'b0, 16'd0};
    tbl[8]  = '{6'b000001, 12'h000, 1'b0, 12'h444, 12'd0, 12'd2, 1'b1, 1'b0, 16'd0};
    tbl[9]  = '{6'b000000, 12'h000, 1'b0, 12'h444, 12'd0, 12'd2, 1'b0, 1'b1, 16'd1};
    tbl[10] = '{6'b000000, 12'h000, 1'b0, 12'h444, 12'd0, 12'd2, 1'b0, 1'b0, 16'd1};
    tbl[11] = '{6'b000001, 12'h000, 1'b0, 12'h444, 12'd0, 12'd2, 1'b0, 1'b0, 16'd1};
    tbl[12] = '{6'b000011, 12'h555, 1'b0, 12'h444, 12'd0, 12'd2, 1'b0, 1'b0, 16'd1};
    tbl[13] = '{6'b011011, 12'h666, 1'b0, 12'h444, 12'd0, 12'd2, 1'b0, 1'b0, 16'd1};
    tbl[14] = '{6'b010001, 12'h000, 1'b0, 12'h444, 12'd0, 12'd2, 1'b1, 1'b0, 16'd1};
    tbl[15] = '{6'b000011, 12'h777, 1'b0, 12'h444, 12'd0, 12'd2, 1'b1, 1'b0, 16'd1};
    tbl[16] = '{6'b001001, 12'h000, 1'b0, 12'h444, 12'd0, 12'd2, 1'b0, 1'b0, 16'd1};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], tbl[i].d);
      chk($sformatf("v%0d_dval", i), o_dval, tbl[i].dv);
      chk($sformatf("v%0d_data", i), o_data, tbl[i].od);
      chk($sformatf("v%0d_x", i), o_x, tbl[i].x);
      chk($sformatf("v%0d_y", i), o_y, tbl[i].y);
      chk($sformatf("v%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("v%0d_done", i), o_done, tbl[i].done);
      chk($sformatf("v%0d_fcnt", i), o_fcnt, tbl[i].fc);
    end

    // Continuous capture of two 3x4 frames
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    send_frame(3, 4, -1);
    send_frame(3, 4, -1);
    chk("cont_dval_count", n_dval, 24);
    chk("cont_done_count", n_done, 2);
    chk("cont_fcnt", o_fcnt, 2);
    chk("cont_busy", o_busy, 1);

    // START in the middle of a frame: that frame is skipped entirely
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0a1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0a2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0a3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0a4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    chk("mid_no_dval", n_dval, 0);
    chk("mid_busy", o_busy, 1);
    send_frame(3, 4, -1);
    chk("mid_dval_count", n_dval, 12);
    chk("mid_fcnt", o_fcnt, 1);

    // SNAP: exactly one frame
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    send_frame(3, 4, -1);
    chk("snap_busy_after_f1", o_busy, 0);
    send_frame(3, 4, -1);
    send_frame(3, 4, -1);
    chk("snap_dval_count", n_dval, 12);
    chk("snap_done_count", n_done, 1);
    chk("snap_fcnt", o_fcnt, 1);

    // STOP during line 1 drains the frame then idles
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    send_frame(3, 4, 1);
    chk("stop_dval_count", n_dval, 12);
    chk("stop_busy", o_busy, 0);
    send_frame(3, 4, -1);
    chk("stop_next_frame", n_dval, 12);
    chk("stop_fcnt", o_fcnt, 1);

    // Reset in the middle of a line
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    send_frame(3, 4, -1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h124);
    chk("rst_pre_dval", o_dval, 1);
    chk("rst_pre_x", o_x, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h125);
    chk("rst_dval", o_dval, 0);
    chk("rst_data", o_data, 0);
    chk("rst_x", o_x, 0);
    chk("rst_y", o_y, 0);
    chk("rst_fcnt", o_fcnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    n_dval = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h126);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h127);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    send_frame(3, 4, -1);
    chk("rst_no_dval", n_dval, 0);
    chk("rst_idle", o_busy, 0);

`ifdef CCD_TEST_PATTERN_EN
    // Test pattern replaces data with {X[5:0], Y[5:0]}; pixel (2,1) gives 12'h081
    do_reset();
    tp = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 4; p++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hfff);
        if (l == 1 && p == 2) begin
          chk("tp_dval", o_dval, 1);
          chk("tp_data", o_data, 12'h081);
        end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    tp = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
